// File: rtl/freq_meter_if.sv
// Result handshake between the frequency meter and its readout consumer.
// The meter publishes freq/flags; the consumer acknowledges with rd_ack.
interface freq_meter_if #(
  parameter int CNT_W = 27
);
  logic             rd_ack;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;
  logic             lost;

  modport master (
    input  rd_ack,
    output freq,
    output freq_valid,
    output overflow,
    output lost
  );

  modport slave (
    output rd_ack,
    input  freq,
    input  freq_valid,
    input  overflow,
    input  lost
  );
endinterface

// File: rtl/freq_meter.sv
// Gated event counter: counts rising edges of sig_in between gate transitions
// and publishes each window's count through a valid/ack result register.
//
// state   | meaning
// IDLE    | not measuring; waiting for enable and a gate transition to open a window
// MEASURE | counting sig_in rising edges; every gate transition closes and reopens a window
module freq_meter #(
  parameter int CNT_W = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        gate,
  input  logic        sig_in,
  output logic        busy,
  freq_meter_if.master res
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       gate_sync, sig_sync;
  logic             ge, se;
  logic [CNT_W-1:0] se_ext;
  logic             cnt_full;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             lost_q, lost_d;

  // Both inputs share one sync depth so se and ge stay cycle-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate_sync <= '0;
      sig_sync  <= '0;
    end else begin
      gate_sync <= {gate_sync[1:0], gate};
      sig_sync  <= {sig_sync[1:0], sig_in};
    end
  end

  assign ge       = gate_sync[2] ^ gate_sync[1];
  assign se       = sig_sync[1] & ~sig_sync[2];
  assign se_ext   = {{(CNT_W-1){1'b0}}, se};
  assign cnt_full = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    freq_d    = freq_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    lost_d    = lost_q;

    if (res.rd_ack && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        ovf_int_d = 1'b0;
        if (enable && ge) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d   = IDLE;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end else if (ge) begin
          // A sig edge landing on the boundary belongs to the closing window.
          freq_d    = cnt_full ? CNT_MAX : (cnt_q + se_ext);
          ovf_d     = ovf_int_q | (cnt_full & se);
          // A simultaneous ack consumes the old result, so nothing is lost.
          if (valid_q && !res.rd_ack) begin
            lost_d = 1'b1;
          end
          valid_d   = 1'b1;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end else if (se) begin
          if (cnt_full) begin
            ovf_int_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q == MEASURE);
  assign res.freq       = freq_q;
  assign res.freq_valid = valid_q;
  assign res.overflow   = ovf_q;
  assign res.lost       = lost_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed phases plus randomized windows, every cycle
// compared against a window-level model that counts edges with plain integers.
module tb_freq_meter;
  localparam int W    = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic reset, enable, gate, sig_in;
  logic busy;

  freq_meter_if #(.CNT_W(W)) res_if ();

  freq_meter #(.CNT_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .gate   (gate),
    .sig_in (sig_in),
    .busy   (busy),
    .res    (res_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: input level history (oldest first) and window-level result state.
  logic g_q[$];
  logic s_q[$];
  int   edges;
  int   m_freq;
  bit   m_busy, m_valid, m_ovf, m_lost;

  int   gcnt, scnt, ghalf, speriod;
  logic gate_r, sig_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    g_q     = '{1'b0, 1'b0, 1'b0, 1'b0};
    s_q     = '{1'b0, 1'b0, 1'b0, 1'b0};
    edges   = 0;
    m_freq  = 0;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_lost  = 1'b0;
  endtask

  // Predicts the effect of the next rising clock edge; gate/sig changes take
  // effect three edges after they are driven, enable/rd_ack on the next edge.
  task automatic model_update(input logic g, input logic s, input logic en, input logic ack);
    bit ge, se, nv;
    g_q.push_back(g);
    s_q.push_back(s);
    void'(g_q.pop_front());
    void'(s_q.pop_front());
    ge = (g_q[1] != g_q[0]);
    se = (s_q[1] && !s_q[0]);
    nv = m_valid && !ack;
    if (!m_busy) begin
      if (en && ge) begin
        m_busy = 1'b1;
        edges  = 0;
      end
    end else if (!en) begin
      m_busy = 1'b0;
      edges  = 0;
    end else begin
      if (se) edges++;
      if (ge) begin
        if (m_valid && !ack) m_lost = 1'b1;
        m_freq = (edges > MAXV) ? MAXV : edges;
        m_ovf  = (edges > MAXV);
        nv     = 1'b1;
        edges  = 0;
      end
    end
    m_valid = nv;
  endtask

  task automatic check_all();
    chk("freq", res_if.freq, m_freq);
    chk("freq_valid", res_if.freq_valid, m_valid);
    chk("overflow", res_if.overflow, m_ovf);
    chk("lost", res_if.lost, m_lost);
    chk("busy", busy, m_busy);
  endtask

  task automatic phase(input int gh, input int sp, input int off);
    ghalf   = gh;
    speriod = sp;
    gcnt    = 0;
    scnt    = off % sp;
  endtask

  task automatic step(input logic en, input int ack_pct);
    logic ack;
    @(negedge clk);
    check_all();
    gcnt++;
    if (gcnt >= ghalf) begin
      gate_r = ~gate_r;
      gcnt   = 0;
    end
    scnt   = (scnt + 1) % speriod;
    sig_r  = (scnt < speriod / 2);
    ack    = ($urandom_range(0, 99) < ack_pct);
    gate   = gate_r;
    sig_in = sig_r;
    enable = en;
    res_if.rd_ack = ack;
    model_update(gate_r, sig_r, en, ack);
  endtask

  task automatic run(input int n, input logic en, input int ack_pct);
    for (int i = 0; i < n; i++) step(en, ack_pct);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freq"}, res_if.freq, 0);
    chk({tag, "_valid"}, res_if.freq_valid, 0);
    chk({tag, "_ovf"}, res_if.overflow, 0);
    chk({tag, "_lost"}, res_if.lost, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    gate = 1'b0;
    sig_in = 1'b0;
    res_if.rd_ack = 1'b0;
    gate_r = 1'b0;
    sig_r = 1'b0;
    model_clear();
    phase(100, 10, 3);

    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b1;
    model_update(gate, sig_in, enable, res_if.rd_ack);

    // Basic windows: first transition only opens, later ones publish 10.
    run(105, 1'b1, 100);
    chk("t1_open_freq", res_if.freq, 0);
    chk("t1_open_busy", busy, 1);
    run(250, 1'b1, 100);
    chk("t1_freq", res_if.freq, 10);
    chk("t1_ovf", res_if.overflow, 0);

    // Saturation, then a clean window after it.
    phase(1000, 2, 0);
    run(2010, 1'b1, 100);
    chk("t2_sat_freq", res_if.freq, 255);
    chk("t2_sat_ovf", res_if.overflow, 1);
    phase(1000, 10, 0);
    run(2005, 1'b1, 100);
    chk("t2_freq", res_if.freq, 100);
    chk("t2_ovf", res_if.overflow, 0);
    chk("t2_lost", res_if.lost, 0);

    // Unacknowledged publishes set lost.
    phase(50, 5, 0);
    run(160, 1'b1, 0);
    chk("t3_freq", res_if.freq, 10);
    chk("t3_valid", res_if.freq_valid, 1);
    chk("t3_lost", res_if.lost, 1);
    run(1, 1'b1, 100);
    run(1, 1'b1, 0);
    chk("t3_ack_valid", res_if.freq_valid, 0);
    chk("t3_ack_lost", res_if.lost, 1);

    // Sig edges coincide with every gate transition.
    phase(100, 10, 0);
    run(305, 1'b1, 100);
    chk("t4_freq", res_if.freq, 10);

    // Enable dropped mid-window, then re-enabled.
    phase(100, 10, 3);
    run(45, 1'b1, 100);
    run(3, 1'b0, 100);
    chk("t5_busy", busy, 0);
    chk("t5_freq_kept", res_if.freq, 10);
    chk("t5_valid", res_if.freq_valid, 0);
    phase(100, 10, 3);
    run(150, 1'b1, 0);
    chk("t5_reopen_valid", res_if.freq_valid, 0);
    chk("t5_reopen_busy", busy, 1);
    run(55, 1'b1, 0);
    chk("t5_pub_valid", res_if.freq_valid, 1);
    chk("t5_pub_freq", res_if.freq, 10);

    // Asynchronous reset mid-window with a result pending.
    run(20, 1'b1, 0);
    chk("t6_pre_valid", res_if.freq_valid, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("t6_async");
    gate_r = 1'b0;
    sig_r  = 1'b0;
    gate   = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    reset = 1'b1;
    model_update(gate, sig_in, enable, res_if.rd_ack);
    phase(100000, 4, 0);
    run(50, 1'b1, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_valid", res_if.freq_valid, 0);

    // Randomized windows, edge rates, ack rates and enable.
    for (int r = 0; r < 6; r++) begin
      int gh;
      gh = $urandom_range(20, 120);
      phase(gh, $urandom_range(2, 12), $urandom_range(0, 11));
      run(gh * 3, ($urandom_range(0, 4) != 0), $urandom_range(0, 100));
    end
    run(5, 1'b1, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
